// File: rtl/com_pkt_rx.sv
// com link far-end packet receiver: hunts 0x55/0xAA sync, decodes the header, writes the payload
// into the receive RAM from a latched base address and checks the trailing XOR checksum.
module com_pkt_rx #(
    parameter logic [11:0] MAX_DLEN = 12'd2048,
    parameter logic [15:0] TOUT     = 16'd4095
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fs,
    output logic        fd,
    input  logic        rxd_vld,
    input  logic [7:0]  rxd,
    input  logic [11:0] ram_init,
    output logic [11:0] ram_txa,
    output logic [7:0]  ram_txd,
    output logic        ram_txen,
    output logic [3:0]  btype,
    output logic [11:0] dlen,
    output logic [1:0]  err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC0,
        S_SYNC1,
        S_HEAD0,
        S_HEAD1,
        S_DATA,
        S_CHK,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [11:0] r_base;
    logic [11:0] r_cnt;
    logic [7:0]  r_acc;
    logic [15:0] r_tout;
    logic [3:0]  r_btype;
    logic [11:0] r_dlen;
    logic [1:0]  r_err;
    logic        r_fd;
    logic [11:0] r_ram_txa;
    logic [7:0]  r_ram_txd;
    logic        r_ram_txen;

    logic        w_in_frame;
    logic        w_tout_hit;
    logic [11:0] w_hdr_dlen;
    logic        w_len_bad;
    logic        w_take;

    // The idle watchdog only runs once the header has started; sync hunting may wait forever.
    assign w_in_frame = (r_state == S_HEAD0) || (r_state == S_HEAD1) ||
                        (r_state == S_DATA)  || (r_state == S_CHK);
    assign w_tout_hit = !rxd_vld && (r_tout >= (TOUT - 16'd1));
    assign w_hdr_dlen = {r_dlen[11:8], rxd};
    assign w_len_bad  = (w_hdr_dlen > MAX_DLEN);
    assign w_take     = fs && rxd_vld;

    // NOTE: async reset plus non-blocking assignments keep every register update race-free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: w_next gets its default before the case, so no path can infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (fs) w_next = S_SYNC0;
            end
            S_DONE: begin
                if (!fs) w_next = S_IDLE;
            end
            default: begin
                if (!fs) begin
                    w_next = S_IDLE;
                end else if (rxd_vld) begin
                    case (r_state)
                        S_SYNC0: begin
                            if (rxd == 8'h55) w_next = S_SYNC1;
                        end
                        S_SYNC1: begin
                            if (rxd == 8'hAA)      w_next = S_HEAD0;
                            else if (rxd == 8'h55) w_next = S_SYNC1;
                            else                   w_next = S_SYNC0;
                        end
                        S_HEAD0: w_next = S_HEAD1;
                        S_HEAD1: begin
                            if (w_len_bad)                w_next = S_DONE;
                            else if (w_hdr_dlen == 12'd0) w_next = S_CHK;
                            else                          w_next = S_DATA;
                        end
                        S_DATA: begin
                            if (r_cnt == (r_dlen - 12'd1)) w_next = S_CHK;
                        end
                        S_CHK:   w_next = S_DONE;
                        default: w_next = r_state;
                    endcase
                end else if (w_in_frame && w_tout_hit) begin
                    w_next = S_DONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_base     <= '0;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_tout     <= '0;
            r_btype    <= '0;
            r_dlen     <= '0;
            r_err      <= '0;
            r_fd       <= 1'b0;
            r_ram_txa  <= '0;
            r_ram_txd  <= '0;
            r_ram_txen <= 1'b0;
        end else begin
            r_ram_txen <= 1'b0;
            r_fd       <= (w_next == S_DONE);
            r_tout     <= (w_in_frame && !rxd_vld) ? (r_tout + 16'd1) : 16'd0;

            case (r_state)
                S_IDLE: begin
                    if (fs) begin
                        r_base <= ram_init;
                        r_err  <= 2'b00;
                        r_acc  <= 8'h00;
                        r_cnt  <= 12'd0;
                    end
                end
                S_HEAD0: begin
                    if (w_take) begin
                        r_btype      <= rxd[7:4];
                        r_dlen[11:8] <= rxd[3:0];
                        r_acc        <= rxd;
                    end
                end
                S_HEAD1: begin
                    if (w_take) begin
                        r_dlen[7:0] <= rxd;
                        r_acc       <= r_acc ^ rxd;
                        if (w_len_bad) r_err[1] <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_take) begin
                        // Address arithmetic is 12-bit, so a base near the top wraps to 0x000.
                        r_ram_txa  <= r_base + r_cnt;
                        r_ram_txd  <= rxd;
                        r_ram_txen <= 1'b1;
                        r_acc      <= r_acc ^ rxd;
                        r_cnt      <= r_cnt + 12'd1;
                    end
                end
                S_CHK: begin
                    if (w_take) r_err[0] <= (rxd != r_acc);
                end
                default: ;
            endcase

            if (fs && w_in_frame && w_tout_hit) r_err[1] <= 1'b1;
        end
    end

    assign fd       = r_fd;
    assign ram_txa  = r_ram_txa;
    assign ram_txd  = r_ram_txd;
    assign ram_txen = r_ram_txen;
    assign btype    = r_btype;
    assign dlen     = r_dlen;
    assign err      = r_err;

endmodule

// File: tb/tb_com_pkt_rx.sv
// Self-checking bench for com_pkt_rx: expected RAM writes are queued as frames are sent and
// popped by a monitor; each scenario task checks the decoded header, errors and fd itself.
module tb_com_pkt_rx;

    localparam logic [15:0] TOUT = 16'd4095;

    typedef struct packed {
        logic [11:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fs = 1'b0;
    logic        fd;
    logic        rxd_vld = 1'b0;
    logic [7:0]  rxd = 8'h00;
    logic [11:0] ram_init = 12'h000;
    logic [11:0] ram_txa;
    logic [7:0]  ram_txd;
    logic        ram_txen;
    logic [3:0]  btype;
    logic [11:0] dlen;
    logic [1:0]  err;

    int   checks = 0;
    int   errors = 0;
    wr_t  exp_q[$];
    logic [7:0] pay[$];

    com_pkt_rx dut (
        .clk      (clk),
        .rst      (rst),
        .fs       (fs),
        .fd       (fd),
        .rxd_vld  (rxd_vld),
        .rxd      (rxd),
        .ram_init (ram_init),
        .ram_txa  (ram_txa),
        .ram_txd  (ram_txd),
        .ram_txen (ram_txen),
        .btype    (btype),
        .dlen     (dlen),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Scoreboard: every write pulse must match the oldest expected {addr,data}.
    always @(negedge clk) begin
        if (rst === 1'b1 && ram_txen === 1'b1) begin
            wr_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%h data=%h, required no write", ram_txa, ram_txd);
            end else begin
                e = exp_q.pop_front();
                if ({ram_txa, ram_txd} !== {e.addr, e.data}) begin
                    errors++;
                    $display("FAIL ram_write: got addr=%h data=%h, required addr=%h data=%h",
                             ram_txa, ram_txd, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rxd     = b;
        rxd_vld = 1'b1;
        tick();
        rxd_vld = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_frame(input logic [7:0] h0, input logic [7:0] h1, input logic [11:0] base,
                              input int gap, input bit bad_chk);
        logic [7:0] chk;
        wr_t        w;
        chk = h0 ^ h1;
        send_byte(8'h55, gap);
        send_byte(8'hAA, gap);
        send_byte(h0, gap);
        send_byte(h1, gap);
        foreach (pay[i]) begin
            w.addr = base + 12'(i);
            w.data = pay[i];
            exp_q.push_back(w);
            chk = chk ^ pay[i];
            send_byte(pay[i], gap);
        end
        send_byte(bad_chk ? 8'hFF : chk, gap);
    endtask

    task automatic start_txn(input logic [11:0] base);
        ram_init = base;
        fs       = 1'b1;
        tick();
    endtask

    task automatic wait_fd(input string name, input int budget);
        int n = 0;
        while (fd !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (fd !== 1'b1) begin
            errors++;
            $display("FAIL %s_fd: fd=%b after %0d cycles, required 1", name, fd, n);
        end
    endtask

    task automatic end_txn(input string name);
        fs = 1'b0;
        tick();
        checks++;
        if (fd !== 1'b0) begin
            errors++;
            $display("FAIL %s_fd_release: fd=%b, required 0", name, fd);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_writes: %0d outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        tick();
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({fd, ram_txen, ram_txa, ram_txd, btype, dlen, err} !== 40'h0) begin
            errors++;
            $display("FAIL reset_outputs: got fd=%b txen=%b a=%h d=%h bt=%h dl=%h err=%b, required all 0",
                     fd, ram_txen, ram_txa, ram_txd, btype, dlen, err);
        end
        tick();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({fd, ram_txen, err} !== 4'h0) begin
            errors++;
            $display("FAIL reset_idle: got fd=%b txen=%b err=%b, required 0", fd, ram_txen, err);
        end
    endtask

    task automatic test_basic();
        start_txn(12'h100);
        pay = '{8'h11, 8'h22, 8'h33};
        send_frame(8'h30, 8'h03, 12'h100, 1, 1'b0);
        wait_fd("basic", 20);
        checks++;
        if ({btype, dlen, err} !== {4'h3, 12'h003, 2'b00}) begin
            errors++;
            $display("FAIL basic_result: got bt=%h dl=%h err=%b, required bt=3 dl=003 err=00", btype, dlen, err);
        end
        repeat (3) tick();
        checks++;
        if (fd !== 1'b1) begin
            errors++;
            $display("FAIL basic_fd_hold: fd=%b while fs high, required 1", fd);
        end
        end_txn("basic");
    endtask

    task automatic test_resync_zero_len();
        start_txn(12'h080);
        pay.delete();
        send_byte(8'h12, 1);
        send_byte(8'h55, 1);
        send_frame(8'h50, 8'h00, 12'h080, 1, 1'b0);
        wait_fd("zero_len", 20);
        checks++;
        if ({btype, dlen, err} !== {4'h5, 12'h000, 2'b00}) begin
            errors++;
            $display("FAIL zero_len_result: got bt=%h dl=%h err=%b, required bt=5 dl=000 err=00", btype, dlen, err);
        end
        end_txn("zero_len");
    endtask

    task automatic test_bad_checksum();
        start_txn(12'h100);
        pay = '{8'h11, 8'h22, 8'h33};
        send_frame(8'h30, 8'h03, 12'h100, 1, 1'b1);
        wait_fd("bad_chk", 20);
        checks++;
        if ({btype, dlen, err} !== {4'h3, 12'h003, 2'b01}) begin
            errors++;
            $display("FAIL bad_chk_result: got bt=%h dl=%h err=%b, required bt=3 dl=003 err=01", btype, dlen, err);
        end
        end_txn("bad_chk");
    endtask

    task automatic test_len_error();
        start_txn(12'h100);
        pay.delete();
        send_frame(8'h1F, 8'hFF, 12'h100, 1, 1'b0);
        wait_fd("len_4095", 20);
        checks++;
        if ({btype, dlen, err} !== {4'h1, 12'hFFF, 2'b10}) begin
            errors++;
            $display("FAIL len_4095_result: got bt=%h dl=%h err=%b, required bt=1 dl=fff err=10", btype, dlen, err);
        end
        end_txn("len_4095");
        start_txn(12'h100);
        send_frame(8'h28, 8'h01, 12'h100, 1, 1'b0);
        wait_fd("len_2049", 20);
        checks++;
        if ({btype, dlen, err} !== {4'h2, 12'h801, 2'b10}) begin
            errors++;
            $display("FAIL len_2049_result: got bt=%h dl=%h err=%b, required bt=2 dl=801 err=10", btype, dlen, err);
        end
        end_txn("len_2049");
    endtask

    task automatic test_max_len();
        start_txn(12'h400);
        pay.delete();
        for (int i = 0; i < 2048; i++) pay.push_back(8'(i) ^ 8'h5A);
        send_frame(8'h08, 8'h00, 12'h400, 0, 1'b0);
        wait_fd("max_len", 20);
        checks++;
        if ({btype, dlen, err} !== {4'h0, 12'h800, 2'b00}) begin
            errors++;
            $display("FAIL max_len_result: got bt=%h dl=%h err=%b, required bt=0 dl=800 err=00", btype, dlen, err);
        end
        end_txn("max_len");
    endtask

    task automatic test_back_to_back_wrap();
        start_txn(12'hFFE);
        pay = '{8'hA1, 8'hB2, 8'hC3};
        send_frame(8'h70, 8'h03, 12'hFFE, 0, 1'b0);
        wait_fd("wrap", 20);
        checks++;
        if ({btype, dlen, err} !== {4'h7, 12'h003, 2'b00}) begin
            errors++;
            $display("FAIL wrap_result: got bt=%h dl=%h err=%b, required bt=7 dl=003 err=00", btype, dlen, err);
        end
        end_txn("wrap");
    endtask

    task automatic test_timeout();
        wr_t w;
        start_txn(12'h010);
        send_byte(8'h55, 1);
        send_byte(8'hAA, 1);
        send_byte(8'h30, 1);
        send_byte(8'h03, 1);
        w.addr = 12'h010;
        w.data = 8'h44;
        exp_q.push_back(w);
        send_byte(8'h44, 0);
        repeat (int'(TOUT) - 2) tick();
        checks++;
        if (fd !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: fd=%b before %0d idle cycles, required 0", fd, TOUT);
        end
        wait_fd("timeout", 10);
        checks++;
        if ({btype, dlen, err} !== {4'h3, 12'h003, 2'b10}) begin
            errors++;
            $display("FAIL timeout_result: got bt=%h dl=%h err=%b, required bt=3 dl=003 err=10", btype, dlen, err);
        end
        end_txn("timeout");
    endtask

    task automatic test_fs_abort();
        wr_t w;
        int  fd_seen = 0;
        start_txn(12'h020);
        send_byte(8'h55, 1);
        send_byte(8'hAA, 1);
        send_byte(8'h30, 1);
        send_byte(8'h03, 1);
        w.addr = 12'h020;
        w.data = 8'h66;
        exp_q.push_back(w);
        send_byte(8'h66, 1);
        fs = 1'b0;
        send_byte(8'h77, 0);
        send_byte(8'h88, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 10; i++) begin
            if (fd === 1'b1) fd_seen++;
            tick();
        end
        checks++;
        if (fd_seen != 0) begin
            errors++;
            $display("FAIL abort_fd: fd high %0d cycles after fs drop, required 0", fd_seen);
        end
        end_txn("abort");
        start_txn(12'h030);
        pay = '{8'h9C};
        send_frame(8'h40, 8'h01, 12'h030, 1, 1'b0);
        wait_fd("after_abort", 20);
        checks++;
        if ({btype, dlen, err} !== {4'h4, 12'h001, 2'b00}) begin
            errors++;
            $display("FAIL after_abort_result: got bt=%h dl=%h err=%b, required bt=4 dl=001 err=00", btype, dlen, err);
        end
        end_txn("after_abort");
    endtask

    task automatic test_async_reset();
        wr_t w;
        start_txn(12'h200);
        send_byte(8'h55, 1);
        send_byte(8'hAA, 1);
        send_byte(8'h30, 1);
        send_byte(8'h03, 1);
        w.addr = 12'h200;
        w.data = 8'h11;
        exp_q.push_back(w);
        send_byte(8'h11, 1);
        send_byte(8'h22, 0);
        checks++;
        if ({ram_txen, ram_txa, ram_txd} !== {1'b1, 12'h201, 8'h22}) begin
            errors++;
            $display("FAIL pre_reset_write: got txen=%b a=%h d=%h, required txen=1 a=201 d=22",
                     ram_txen, ram_txa, ram_txd);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({fd, ram_txen, ram_txa, ram_txd, btype, dlen, err} !== 40'h0) begin
            errors++;
            $display("FAIL async_reset: got fd=%b txen=%b a=%h d=%h bt=%h dl=%h err=%b, required all 0",
                     fd, ram_txen, ram_txa, ram_txd, btype, dlen, err);
        end
        fs = 1'b0;
        tick();
        rst = 1'b1;
        end_txn("async_reset");
        start_txn(12'h300);
        pay = '{8'h01, 8'h02};
        send_frame(8'h90, 8'h02, 12'h300, 1, 1'b0);
        wait_fd("after_reset", 20);
        checks++;
        if ({btype, dlen, err} !== {4'h9, 12'h002, 2'b00}) begin
            errors++;
            $display("FAIL after_reset_result: got bt=%h dl=%h err=%b, required bt=9 dl=002 err=00", btype, dlen, err);
        end
        end_txn("after_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_resync_zero_len();
        test_bad_checksum();
        test_len_error();
        test_max_len();
        test_back_to_back_wrap();
        test_timeout();
        test_fs_abort();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
